// File: rtl/store_issue_ctrl_pkg.sv
// Shared definitions for the store issue controller: store-type encodings,
// FSM state encoding and the default memory-response timeout.
package store_issue_ctrl_pkg;

    // Store types follow the RV32 S-type funct3 encoding.
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    localparam int STORE_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } store_state_e;

endpackage

// File: rtl/store_issue_ctrl_lane_align.sv
// store_lane_align: combinational byte-enable / lane-replication logic for one
// store. Only the two low effective-address bits matter here.
module store_lane_align
    import store_issue_ctrl_pkg::*;
(
    input  logic [2:0]  st_control,
    input  logic [1:0]  ea,
    input  logic [31:0] st_data,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        misaligned,
    output logic        invalid
);

    // Decode store size into lane enables, replicated data and fault flags.
    always_comb begin
        mem_be     = 4'b0000;
        mem_wdata  = 32'h0000_0000;
        misaligned = 1'b0;
        invalid    = 1'b0;
        case (st_control)
            SB: begin
                mem_be    = 4'b0001 << ea;
                mem_wdata = {4{st_data[7:0]}};
            end
            SH: begin
                // ea[0] is ignored so an untrapped misaligned half lands on its cleared address.
                mem_be     = ea[1] ? 4'b1100 : 4'b0011;
                mem_wdata  = {2{st_data[15:0]}};
                misaligned = ea[0];
            end
            SW: begin
                mem_be     = 4'b1111;
                mem_wdata  = st_data;
                misaligned = (ea != 2'b00);
            end
            default: begin
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_issue_ctrl.sv
// Store issue controller: captures one store, drives the data-memory
// request/grant/done handshake and reports completion or error.
// Optional build macro: STORE_MISALIGN_TRAP_EN (misaligned SH/SW report an error).
module store_issue_ctrl
    import store_issue_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = STORE_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_control,
    input  logic [ADDR_W-1:0] st_base,
    input  logic [11:0]       st_imm,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              st_err,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_done
);

`ifdef STORE_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    store_state_e      state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              st_ready_r, st_done_r, st_err_r, busy_r, mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [3:0]        mem_be_r;

    logic [ADDR_W-1:0] ea_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic              misaligned_s, invalid_s, reject_s;

    assign ea_s     = st_base + {{(ADDR_W-12){st_imm[11]}}, st_imm};
    assign reject_s = invalid_s | (misaligned_s & TRAP_EN);

    store_lane_align u_lane_align (
        .st_control (st_control),
        .ea         (ea_s[1:0]),
        .st_data    (st_data),
        .mem_be     (be_s),
        .mem_wdata  (wdata_s),
        .misaligned (misaligned_s),
        .invalid    (invalid_s)
    );

    // Control FSM; every output is registered and set up for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            st_ready_r  <= 1'b1;
            st_done_r   <= 1'b0;
            st_err_r    <= 1'b0;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (st_valid) begin
                        mem_addr_r  <= {ea_s[ADDR_W-1:2], 2'b00};
                        mem_wdata_r <= wdata_s;
                        mem_be_r    <= be_s;
                        st_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        if (reject_s) begin
                            state_r   <= RESP;
                            st_done_r <= 1'b1;
                            st_err_r  <= 1'b1;
                        end else begin
                            state_r   <= REQ;
                            mem_req_r <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        cnt_r     <= '0;
                        if (mem_done) begin
                            state_r   <= RESP;
                            st_done_r <= 1'b1;
                            st_err_r  <= 1'b0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 1'b1;
                    // A done arriving in the expiry cycle still counts as success.
                    if (mem_done) begin
                        state_r   <= RESP;
                        st_done_r <= 1'b1;
                        st_err_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= RESP;
                        st_done_r <= 1'b1;
                        st_err_r  <= 1'b1;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    cnt_r      <= '0;
                    st_done_r  <= 1'b0;
                    st_err_r   <= 1'b0;
                    busy_r     <= 1'b0;
                    st_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= '0;
                    st_done_r  <= 1'b0;
                    st_err_r   <= 1'b0;
                    busy_r     <= 1'b0;
                    mem_req_r  <= 1'b0;
                    st_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign st_ready  = st_ready_r;
    assign st_done   = st_done_r;
    assign st_err    = st_err_r;
    assign busy      = busy_r;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;

endmodule

// File: doc/store_issue_ctrl.md
Name: store_issue_ctrl

Overview:
- Sequences one decoded store instruction (`SB`/`SH`/`SW`) from the execute stage into data memory.
- Computes the effective address, generates byte enables and lane-replicated write data, then runs the request/grant/done handshake.
- Reports completion or error back to the pipeline.
- Sits between the store decoder / register-file read and the data-memory port; holds one store in flight.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data-memory word width; fixed at 32, with 4 byte lanes.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for mem_done after grant before an error is flagged; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- st_valid  in  1  store request from pipeline.
- st_ready  out  1  controller can accept a store.
- st_control  in  3  store type; uses the `SB`/`SH`/`SW` encodings from processor_defines.sv, and any other value is invalid.
- st_base  in  ADDR_W  rs1 register value.
- st_imm  in  12  S-type immediate.
- st_data  in  DATA_W  rs2 register value.
- st_done  out  1  one-cycle completion pulse.
- st_err  out  1  qualifies st_done; 1 = store not performed, or timed out.
- busy  out  1  store in flight (state != IDLE).
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  memory accepted the request.
- mem_done  in  1  write completed.

Behaviour:
- Reset values: all outputs 0 except st_ready = 1; state = IDLE; timeout counter = 0.
- A reset mid-operation abandons the store: mem_req drops at the reset edge and no st_done is produced.
- Effective address: ea = st_base + sign_extend(st_imm), modulo 2^ADDR_W (wrap, no overflow flag).
- Store type SB:
  - mem_be = 4'b0001 << ea[1:0].
  - mem_wdata = {4{st_data[7:0]}}.
- Store type SH:
  - mem_be = ea[1] ? 4'b1100 : 4'b0011.
  - mem_wdata = {2{st_data[15:0]}}.
- Store type SW:
  - mem_be = 4'b1111.
  - mem_wdata = st_data.
- mem_addr = {ea[ADDR_W-1:2], 2'b00}.
- Misaligned stores: SH with ea[0] = 1, or SW with ea[1:0] != 0 (handling set by the optional feature).
- States: IDLE, REQ, WAIT, RESP.
  - IDLE: st_ready = 1. When st_valid, all inputs are captured into registers that same cycle.
    - Invalid st_control (or a trapped misalignment) -> RESP with error.
    - Otherwise -> REQ.
  - REQ: mem_req = 1; mem_addr, mem_wdata and mem_be are held stable until mem_gnt.
    - mem_gnt only -> WAIT.
    - mem_gnt and mem_done in the same cycle -> RESP, no error.
  - WAIT: mem_req = 0; the counter increments every cycle.
    - mem_done -> RESP, no error.
    - Counter reaches TIMEOUT_CYCLES without mem_done -> RESP with error.
    - mem_done arriving in the expiry cycle wins (no error).
  - RESP: st_done = 1 for exactly one cycle, st_err as determined; counter cleared; -> IDLE.
- Latency: store accepted at cycle N; mem_req rises at N+1; with same-cycle grant and done, st_done is asserted at N+2.
- Error path: st_done is asserted at N+1 and mem_req is never asserted.
- Throughput: st_ready is low in REQ, WAIT and RESP; a new store can be accepted in the cycle after RESP.
- mem_gnt and mem_done are ignored in IDLE and RESP.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: a misaligned SH/SW produces st_done with st_err = 1 and no memory access.
- Undefined: low address bits are cleared (SH to ea & ~1, SW to ea & ~3); byte enables are computed from the cleared address and the access proceeds normally.

Decomposition:
- Add to processor_defines.sv: the state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3) and a STORE_TIMEOUT_DEFAULT constant (255).
- The `SB`/`SH`/`SW` encodings are reused from that file unchanged.
- One combinational sub-module, store_lane_align: inputs st_control, ea, st_data; outputs mem_be, mem_wdata, misaligned, invalid. The top level holds the FSM, capture registers and timeout counter.

Test Plan:
- SB with st_base = 0x1000, st_imm = 0x003, st_data = 0xA5 -> mem_addr = 0x1000, mem_be = 4'b1000, mem_wdata = 0xA5A5A5A5; gnt and done same cycle -> st_done at N+2, st_err = 0.
- SH with st_base = 0x2000, st_imm = 0xFFE (= -2) -> ea = 0x1FFE, mem_addr = 0x1FFC, mem_be = 4'b1100; mem_gnt delayed 3 cycles -> mem_req and outputs held stable throughout.
- SW with ea = 0x1002:
  - With STORE_MISALIGN_TRAP_EN: st_done at N+1, st_err = 1, mem_req never asserted.
  - Without it: mem_addr = 0x1000, mem_be = 4'b1111.
- TIMEOUT_CYCLES = 4, grant with mem_done never asserted -> st_done with st_err = 1 after 4 WAIT cycles; next store accepted afterwards.
- st_control = 3'b111 -> error response, no memory access.
- rst asserted while in WAIT -> next cycle state IDLE, st_ready = 1, no st_done.
- st_base = 0xFFFFFFFC, st_imm = 0x004 -> ea wraps to 0x00000000.
